// File: rtl/mem_gpio_irq_if.sv
// iomem bus bundle between the address-decode master and a peripheral slave.
// Single-cycle-ack protocol: valid is held until ready, wstrb==0 marks a read.
interface mem_gpio_irq_if;
    logic        mem_valid;
    logic        mem_ready;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_rdata;

    modport master (
        output mem_valid,
        output mem_addr,
        output mem_wdata,
        output mem_wstrb,
        input  mem_ready,
        input  mem_rdata
    );

    modport slave (
        input  mem_valid,
        input  mem_addr,
        input  mem_wdata,
        input  mem_wstrb,
        output mem_ready,
        output mem_rdata
    );
endinterface

// File: rtl/mem_gpio_irq.sv
// Memory-mapped GPIO with input synchronisers, atomic SET/CLR/TGL of the
// output latch, and per-pin rising/falling edge capture into a W1C pending
// register whose OR drives a registered level interrupt.
module mem_gpio_irq #(
    parameter int WIDTH       = 32,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rstn,
    mem_gpio_irq_if.slave    bus,
    output logic [WIDTH-1:0] gpio_oe,
    output logic [WIDTH-1:0] gpio_do,
    input  logic [WIDTH-1:0] gpio_di,
    output logic             irq
);

    // Register indices (mem_addr[5:2])
    localparam logic [3:0] IDX_DOUT    = 4'd0;
    localparam logic [3:0] IDX_OE      = 4'd1;
    localparam logic [3:0] IDX_DIN     = 4'd2;
    localparam logic [3:0] IDX_SET     = 4'd3;
    localparam logic [3:0] IDX_CLR     = 4'd4;
    localparam logic [3:0] IDX_TGL     = 4'd5;
    localparam logic [3:0] IDX_RISE_EN = 4'd6;
    localparam logic [3:0] IDX_FALL_EN = 4'd7;
    localparam logic [3:0] IDX_PEND    = 4'd8;

    typedef enum logic {
        ST_IDLE,
        ST_ACK
    } state_t;

    state_t state_reg, state_next;
    logic   accept;

    logic [WIDTH-1:0] dout_reg, dout_next;
    logic [WIDTH-1:0] oe_reg, oe_next;
    logic [WIDTH-1:0] rise_en_reg, rise_en_next;
    logic [WIDTH-1:0] fall_en_reg, fall_en_next;
    logic [WIDTH-1:0] pend_reg, pend_next;
    logic [WIDTH-1:0] prev_reg;
    logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_reg;
    logic             irq_reg;
    logic [31:0]      rdata_reg;
    logic [31:0]      rd_val;

    logic [31:0]      byte_mask;
    logic [WIDTH-1:0] wmask;
    logic [WIDTH-1:0] wbits;
    logic [WIDTH-1:0] clr_mask;
    logic [WIDTH-1:0] sync_val;
    logic [WIDTH-1:0] rise;
    logic [WIDTH-1:0] fall;
    logic [3:0]       idx;
    logic             is_wr;
    logic             unused_bits;

    // Expand byte strobes into a bit mask; bits above WIDTH are simply dropped.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_byte_mask
            assign byte_mask[8*gi +: 8] = {8{bus.mem_wstrb[gi]}};
        end
    endgenerate

    assign idx         = bus.mem_addr[5:2];
    assign is_wr       = accept && (bus.mem_wstrb != 4'b0000);
    assign wmask       = byte_mask[WIDTH-1:0];
    assign wbits       = bus.mem_wdata[WIDTH-1:0] & wmask;
    assign sync_val    = sync_reg[SYNC_STAGES-1];
    assign rise        = sync_val & ~prev_reg;
    assign fall        = ~sync_val & prev_reg;
    assign unused_bits = ^{bus.mem_addr[31:6], bus.mem_addr[1:0], bus.mem_wdata, byte_mask};

    // Handshake state register; an aborted access simply falls back to idle.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Accept only from idle so a valid still held during the ack cycle is ignored.
    always_comb begin
        state_next = state_reg;
        accept     = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (bus.mem_valid) begin
                    accept     = 1'b1;
                    state_next = ST_ACK;
                end
            end
            ST_ACK: begin
                state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Next values of the writable registers, including the atomic DOUT ops.
    always_comb begin
        dout_next    = dout_reg;
        oe_next      = oe_reg;
        rise_en_next = rise_en_reg;
        fall_en_next = fall_en_reg;
        clr_mask     = '0;
        if (is_wr) begin
            case (idx)
                IDX_DOUT:    dout_next    = (dout_reg & ~wmask) | wbits;
                IDX_OE:      oe_next      = (oe_reg & ~wmask) | wbits;
                IDX_SET:     dout_next    = dout_reg | wbits;
                IDX_CLR:     dout_next    = dout_reg & ~wbits;
                IDX_TGL:     dout_next    = dout_reg ^ wbits;
                IDX_RISE_EN: rise_en_next = (rise_en_reg & ~wmask) | wbits;
                IDX_FALL_EN: fall_en_next = (fall_en_reg & ~wmask) | wbits;
                IDX_PEND:    clr_mask     = wbits;
                default:     ;
            endcase
        end
        // New edges are OR-ed in after the clear, so a same-cycle edge wins.
        pend_next = (pend_reg & ~clr_mask) | (rise & rise_en_reg) | (fall & fall_en_reg);
    end

    // Read mux; write-only and unmapped indices read as zero.
    always_comb begin
        rd_val = '0;
        case (idx)
            IDX_DOUT:    rd_val[WIDTH-1:0] = dout_reg;
            IDX_OE:      rd_val[WIDTH-1:0] = oe_reg;
            IDX_DIN:     rd_val[WIDTH-1:0] = sync_val;
            IDX_RISE_EN: rd_val[WIDTH-1:0] = rise_en_reg;
            IDX_FALL_EN: rd_val[WIDTH-1:0] = fall_en_reg;
            IDX_PEND:    rd_val[WIDTH-1:0] = pend_reg;
            default:     rd_val = '0;
        endcase
    end

    // Register file, synchroniser chain, edge history and bus response flops.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            dout_reg    <= '0;
            oe_reg      <= '0;
            rise_en_reg <= '0;
            fall_en_reg <= '0;
            pend_reg    <= '0;
            prev_reg    <= '0;
            sync_reg    <= '0;
            irq_reg     <= 1'b0;
            rdata_reg   <= '0;
        end else begin
            dout_reg    <= dout_next;
            oe_reg      <= oe_next;
            rise_en_reg <= rise_en_next;
            fall_en_reg <= fall_en_next;
            pend_reg    <= pend_next;
            prev_reg    <= sync_val;
            if (SYNC_STAGES > 1) begin
                sync_reg <= {sync_reg[SYNC_STAGES-2:0], gpio_di};
            end else begin
                sync_reg[0] <= gpio_di;
            end
            // irq is a flop of the OR so the pin never glitches.
            irq_reg     <= |pend_next;
            // rdata only carries data during the ack cycle, zero otherwise.
            rdata_reg   <= accept ? rd_val : 32'h0;
        end
    end

    assign bus.mem_ready = (state_reg == ST_ACK);
    assign bus.mem_rdata = rdata_reg;
    assign gpio_do       = dout_reg;
    assign gpio_oe       = oe_reg;
    assign irq           = irq_reg;

endmodule

// File: tb/tb_mem_gpio_irq.sv
// Directed bench for mem_gpio_irq (WIDTH=12, SYNC_STAGES=2): a vector table
// of bus accesses with expected read data and pin state, followed by
// hand-written sequences for reset, edge timing and same-cycle corner cases.
module tb_mem_gpio_irq;

    localparam int W = 12;

    logic         clk = 1'b0;
    logic         rstn;
    logic [W-1:0] gpio_oe;
    logic [W-1:0] gpio_do;
    logic [W-1:0] gpio_di;
    logic         irq;

    int errors = 0;
    int checks = 0;
    logic irq_at_ready;

    mem_gpio_irq_if bus ();

    mem_gpio_irq #(
        .WIDTH(W),
        .SYNC_STAGES(2)
    ) dut (
        .clk    (clk),
        .rstn   (rstn),
        .bus    (bus),
        .gpio_oe(gpio_oe),
        .gpio_do(gpio_do),
        .gpio_di(gpio_di),
        .irq    (irq)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  idx;
        logic [31:0] wd;
        logic [3:0]  st;
        logic [31:0] exp_rd;
        logic [W-1:0] exp_do;
        logic [W-1:0] exp_oe;
    } vec_t;

    vec_t vecs[24];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // One bus access; called and returns at #1 after a rising edge.
    task automatic access(input logic [3:0] idx, input logic [31:0] wd,
                          input logic [3:0] st, output logic [31:0] rd);
        int n;
        bus.mem_valid = 1'b1;
        bus.mem_addr  = {26'd0, idx, 2'b00};
        bus.mem_wdata = wd;
        bus.mem_wstrb = st;
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!bus.mem_ready && n < 8);
        check("ack latency", 32'(n), 32'd1);
        rd           = bus.mem_rdata;
        irq_at_ready = irq;
        bus.mem_valid = 1'b0;
        bus.mem_wstrb = 4'h0;
        @(posedge clk);
        #1;
        check("ready one cycle", {31'd0, bus.mem_ready}, 32'd0);
        check("rdata idle zero", bus.mem_rdata, 32'd0);
        $display("acc idx=%0d wd=%08h st=%h rd=%08h do=%03h oe=%03h irq=%0b",
                 idx, wd, st, rd, gpio_do, gpio_oe, irq);
    endtask

    initial begin
        logic [31:0] rd;

        // idx, wdata, wstrb, expected rdata (reads only), expected do, expected oe
        vecs[0]  = '{4'd0,  32'h0000_00F0, 4'hF, 32'h0,          12'h0F0, 12'h000};
        vecs[1]  = '{4'd3,  32'h0000_000F, 4'hF, 32'h0,          12'h0FF, 12'h000};
        vecs[2]  = '{4'd4,  32'h0000_0030, 4'hF, 32'h0,          12'h0CF, 12'h000};
        vecs[3]  = '{4'd5,  32'h0000_0081, 4'hF, 32'h0,          12'h04E, 12'h000};
        vecs[4]  = '{4'd0,  32'h0,         4'h0, 32'h0000_004E,  12'h04E, 12'h000};
        vecs[5]  = '{4'd3,  32'h0,         4'h0, 32'h0,          12'h04E, 12'h000};
        vecs[6]  = '{4'd0,  32'h0,         4'hF, 32'h0,          12'h000, 12'h000};
        vecs[7]  = '{4'd0,  32'hFFFF_FFFF, 4'h2, 32'h0,          12'hF00, 12'h000};
        vecs[8]  = '{4'd0,  32'h0,         4'h0, 32'h0000_0F00,  12'hF00, 12'h000};
        vecs[9]  = '{4'd1,  32'hFFFF_FFFF, 4'h1, 32'h0,          12'hF00, 12'h0FF};
        vecs[10] = '{4'd1,  32'h0,         4'h0, 32'h0000_00FF,  12'hF00, 12'h0FF};
        vecs[11] = '{4'd3,  32'h0000_0A05, 4'h1, 32'h0,          12'hF05, 12'h0FF};
        vecs[12] = '{4'd4,  32'h0000_0FFF, 4'h2, 32'h0,          12'h005, 12'h0FF};
        vecs[13] = '{4'd5,  32'hFFFF_FFFF, 4'hC, 32'h0,          12'h005, 12'h0FF};
        vecs[14] = '{4'd0,  32'h0,         4'h0, 32'h0000_0005,  12'h005, 12'h0FF};
        vecs[15] = '{4'd12, 32'h0,         4'h0, 32'h0,          12'h005, 12'h0FF};
        vecs[16] = '{4'd10, 32'hFFFF_FFFF, 4'hF, 32'h0,          12'h005, 12'h0FF};
        vecs[17] = '{4'd6,  32'h1234_5678, 4'hF, 32'h0,          12'h005, 12'h0FF};
        vecs[18] = '{4'd6,  32'h0,         4'h0, 32'h0000_0678,  12'h005, 12'h0FF};
        vecs[19] = '{4'd1,  32'h0,         4'hF, 32'h0,          12'h005, 12'h000};
        vecs[20] = '{4'd2,  32'h0,         4'h0, 32'h0000_0A5A,  12'h005, 12'h000};
        vecs[21] = '{4'd6,  32'h0000_0001, 4'hF, 32'h0,          12'h005, 12'h000};
        vecs[22] = '{4'd8,  32'h0,         4'h0, 32'h0,          12'h005, 12'h000};
        vecs[23] = '{4'd7,  32'h0,         4'h0, 32'h0,          12'h005, 12'h000};

        bus.mem_valid = 1'b0;
        bus.mem_addr  = 32'h0;
        bus.mem_wdata = 32'h0;
        bus.mem_wstrb = 4'h0;
        gpio_di       = '1;
        rstn          = 1'b0;

        // Reset values with all inputs high
        wait_cycles(4);
        check("rst mem_ready", {31'd0, bus.mem_ready}, 32'd0);
        check("rst mem_rdata", bus.mem_rdata, 32'd0);
        check("rst gpio_oe", 32'(gpio_oe), 32'd0);
        check("rst gpio_do", 32'(gpio_do), 32'd0);
        check("rst irq", {31'd0, irq}, 32'd0);
        rstn = 1'b1;
        wait_cycles(6);
        check("post-rst irq", {31'd0, irq}, 32'd0);
        access(4'd8, 32'h0, 4'h0, rd);
        check("post-rst PEND", rd, 32'h0);
        access(4'd2, 32'h0, 4'h0, rd);
        check("post-rst DIN", rd, 32'h0000_0FFF);

        // Table-driven register accesses
        gpio_di = 12'hA5A;
        wait_cycles(4);
        for (int i = 0; i < 24; i++) begin
            access(vecs[i].idx, vecs[i].wd, vecs[i].st, rd);
            if (vecs[i].st == 4'h0)
                check($sformatf("vec%0d rdata", i), rd, vecs[i].exp_rd);
            check($sformatf("vec%0d gpio_do", i), 32'(gpio_do), 32'(vecs[i].exp_do));
            check($sformatf("vec%0d gpio_oe", i), 32'(gpio_oe), 32'(vecs[i].exp_oe));
        end

        // valid held through the ack cycle must not start a second access
        bus.mem_valid = 1'b1;
        bus.mem_addr  = {26'd0, 4'd5, 2'b00};
        bus.mem_wdata = 32'h1;
        bus.mem_wstrb = 4'h1;
        wait_cycles(1);
        check("held ack", {31'd0, bus.mem_ready}, 32'd1);
        wait_cycles(1);
        check("held no re-ack", {31'd0, bus.mem_ready}, 32'd0);
        check("held tgl once", 32'(gpio_do), 32'h004);
        bus.mem_valid = 1'b0;
        bus.mem_wstrb = 4'h0;
        wait_cycles(2);
        check("held tgl settled", 32'(gpio_do), 32'h004);

        // Rising edge on pin 0: irq rises after edge k+2
        gpio_di = '0;
        wait_cycles(5);
        check("pre-edge irq", {31'd0, irq}, 32'd0);
        gpio_di = 12'h001;          // captured at the next edge k
        wait_cycles(1);             // after k
        check("rise irq k", {31'd0, irq}, 32'd0);
        wait_cycles(1);             // after k+1
        check("rise irq k+1", {31'd0, irq}, 32'd0);
        wait_cycles(1);             // after k+2
        check("rise irq k+2", {31'd0, irq}, 32'd1);
        access(4'd8, 32'h0, 4'h0, rd);
        check("rise PEND", rd, 32'h1);
        access(4'd2, 32'h0, 4'h0, rd);
        check("rise DIN", rd, 32'h1);
        access(4'd8, 32'h1, 4'hF, rd);
        check("w1c irq next cycle", {31'd0, irq_at_ready}, 32'd0);
        access(4'd8, 32'h0, 4'h0, rd);
        check("w1c PEND", rd, 32'h0);

        // Clear/edge collision on pin 3
        access(4'd7, 32'h8, 4'hF, rd);
        gpio_di = 12'h009;
        wait_cycles(5);
        check("pin3 rise ignored irq", {31'd0, irq}, 32'd0);
        gpio_di = 12'h001;
        wait_cycles(5);
        check("pin3 fall irq", {31'd0, irq}, 32'd1);
        access(4'd8, 32'h0, 4'h0, rd);
        check("pin3 fall PEND", rd, 32'h8);
        gpio_di = 12'h009;
        wait_cycles(5);
        gpio_di = 12'h001;          // fall lands in PEND at the 3rd edge from here
        wait_cycles(2);
        access(4'd8, 32'h8, 4'h1, rd);  // W1C sampled on that same edge
        check("collision irq", {31'd0, irq}, 32'd1);
        access(4'd8, 32'h0, 4'h0, rd);
        check("collision PEND", rd, 32'h8);
        access(4'd8, 32'h8, 4'h2, rd);  // wrong byte strobe: no clear
        access(4'd8, 32'h0, 4'h0, rd);
        check("w1c unstrobed PEND", rd, 32'h8);
        access(4'd8, 32'h8, 4'h1, rd);
        check("final clear irq", {31'd0, irq}, 32'd0);

        // Reset asserted on the same edge that samples a write to OE
        bus.mem_valid = 1'b1;
        bus.mem_addr  = {26'd0, 4'd1, 2'b00};
        bus.mem_wdata = 32'hFF;
        bus.mem_wstrb = 4'hF;
        rstn = 1'b0;
        wait_cycles(1);
        check("rst-acc ready", {31'd0, bus.mem_ready}, 32'd0);
        check("rst-acc oe", 32'(gpio_oe), 32'd0);
        bus.mem_valid = 1'b0;
        bus.mem_wstrb = 4'h0;
        wait_cycles(1);
        rstn = 1'b1;
        for (int i = 0; i < 3; i++) begin
            wait_cycles(1);
            check("rst-acc no ready", {31'd0, bus.mem_ready}, 32'd0);
        end
        check("rst-acc oe after", 32'(gpio_oe), 32'd0);
        access(4'd1, 32'h0, 4'h0, rd);
        check("rst-acc OE read", rd, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
